// File: rtl/mlu_ctrl_if.sv
// mlu_ctrl_if: EX-side request/HI-LO bus plus the MLU launch/result bus.
// master = EX stage and MLU side (testbench or parent), slave = mlu_ctrl.
interface mlu_ctrl_if;
  // EX stage request and MTHI/MTLO writes
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hilo_wdata;
  // EX stage status and architectural state
  logic        stall;
  logic        done;
  logic [31:0] gpr_result;
  logic        err;
  logic [31:0] hi;
  logic [31:0] lo;
  // MLU side
  logic        mlu_start;
  logic        mlu_sign;
  logic [31:0] mlu_op1;
  logic [31:0] mlu_op2;
  logic        mlu_ready;
  logic [63:0] mlu_result;

  modport master (
    output req_valid, req_op, req_a, req_b, flush, hi_we, lo_we, hilo_wdata,
    output mlu_ready, mlu_result,
    input  stall, done, gpr_result, err, hi, lo,
    input  mlu_start, mlu_sign, mlu_op1, mlu_op2
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, hi_we, lo_we, hilo_wdata,
    input  mlu_ready, mlu_result,
    output stall, done, gpr_result, err, hi, lo,
    output mlu_start, mlu_sign, mlu_op1, mlu_op2
  );
endinterface

// File: rtl/mlu_ctrl.sv
// mlu_ctrl: sequencing controller between the EX stage and the 7-stage MLU.
// One request in flight; operands/sign held for the whole RUN phase, the
// single-cycle MLU result is captured into HI/LO (or the GPR result), and a
// one-cycle GAP returns the MLU to its idle state before the next accept.
// Optional feature: define MLU_ACC_EN to enable MADD/MADDU/MSUB/MSUBU
// accumulation into {hi,lo}; otherwise ops 4-7 complete as no-ops like op 3.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO writes accepted
// RUN   | mlu_start high, waiting for mlu_ready (flush / timeout abort)
// GAP   | one cycle with mlu_start low; done/err pulse visible here
module mlu_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input logic       clk,
  input logic       rst,
  mlu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic [31:0]      op1_q;
  logic [31:0]      op2_q;
  logic             sign_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      gpr_q;
  logic             done_q;
  logic             err_q;

  logic             op_nop;
  logic             is_idle;
  logic             accept;
  logic             nop_hit;
  logic [63:0]      hilo_d;
  logic [31:0]      gpr_d;

  // Ops that never launch the MLU and simply complete one cycle later
`ifdef MLU_ACC_EN
  assign op_nop = (bus.req_op == 3'd3);
`else
  assign op_nop = (bus.req_op == 3'd3) || bus.req_op[2];
`endif

  assign is_idle = (state_q == IDLE);
  assign accept  = is_idle && bus.req_valid && !bus.flush && !op_nop;
  assign nop_hit = is_idle && bus.req_valid && !bus.flush && op_nop;

  // Value written at capture, selected by the latched opcode
  always_comb begin
    hilo_d = {hi_q, lo_q};
    gpr_d  = gpr_q;
    case (op_q)
      3'd0, 3'd1: hilo_d = bus.mlu_result;
      3'd2:       gpr_d  = bus.mlu_result[31:0];
`ifdef MLU_ACC_EN
      3'd4, 3'd5: hilo_d = {hi_q, lo_q} + bus.mlu_result;
      3'd6, 3'd7: hilo_d = {hi_q, lo_q} - bus.mlu_result;
`endif
      default: ;
    endcase
  end

  // Sequencing FSM with registered done/err pulses and HI/LO state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      sign_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      gpr_q   <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.hilo_wdata;
          if (bus.lo_we) lo_q <= bus.hilo_wdata;
          if (accept) begin
            op1_q   <= bus.req_a;
            op2_q   <= bus.req_b;
            op_q    <= bus.req_op;
            sign_q  <= ~bus.req_op[0];
            cnt_q   <= '0;
            state_q <= RUN;
          end else if (nop_hit) begin
            done_q <= 1'b1;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.flush) begin
            state_q <= GAP;
          end else if (bus.mlu_ready) begin
            // mlu_result is only valid in this first ready cycle
            {hi_q, lo_q} <= hilo_d;
            gpr_q        <= gpr_d;
            done_q       <= 1'b1;
            state_q      <= GAP;
          end else if (cnt_q == TO_CNT) begin
            err_q   <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output decode; stall drops in GAP so EX advances while done pulses
  always_comb begin
    bus.stall      = bus.req_valid &&
                     ((is_idle && !bus.flush && !op_nop) || (state_q == RUN));
    bus.mlu_start  = (state_q == RUN);
    bus.mlu_sign   = sign_q;
    bus.mlu_op1    = op1_q;
    bus.mlu_op2    = op2_q;
    bus.hi         = hi_q;
    bus.lo         = lo_q;
    bus.gpr_result = gpr_q;
    bus.done       = done_q;
    bus.err        = err_q;
  end

endmodule

// File: tb/tb_mlu_ctrl.sv
// tb_mlu_ctrl: drives mlu_ctrl against a behavioural MLU stub that raises
// ready in the 8th mlu_start cycle with the product for that one cycle.
// Expected HI/LO/GPR values are queued when a request is driven and popped
// when done pulses.
module tb_mlu_ctrl;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;

  mlu_ctrl_if bus ();

  mlu_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // MLU stub
  int          stub_cnt;
  bit          stub_hang;
  logic [63:0] stub_prod;

  always @(posedge clk or posedge rst) begin
    if (rst)                 stub_cnt <= 0;
    else if (!bus.mlu_start) stub_cnt <= 0;
    else if (stub_cnt < 100) stub_cnt <= stub_cnt + 1;
  end

  always_comb begin
    if (bus.mlu_sign)
      stub_prod = $signed({{32{bus.mlu_op1[31]}}, bus.mlu_op1}) *
                  $signed({{32{bus.mlu_op2[31]}}, bus.mlu_op2});
    else
      stub_prod = {32'd0, bus.mlu_op1} * {32'd0, bus.mlu_op2};
    bus.mlu_ready  = bus.mlu_start && !stub_hang && (stub_cnt >= 7);
    bus.mlu_result = (bus.mlu_ready && stub_cnt == 7) ? stub_prod : 64'd0;
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] gpr;
    bit          chk_gpr;
  } exp_t;

  typedef struct {
    int n_start;
    int n_lat;
    int n_stall;
    bit pre_stall;
    bit sign;
    bit seen_done;
    bit seen_err;
  } obs_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Stimulus: present one request, hold it until done/err, observe timing
  task automatic drive_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output obs_t o);
    o = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    #1 o.pre_stall = bus.stall;
    @(posedge clk);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      o.n_lat++;
      if (bus.mlu_start) o.n_start++;
      if (bus.stall) o.n_stall++;
      if (o.n_lat == 1) o.sign = bus.mlu_sign;
      if (bus.err) o.seen_err = 1'b1;
      if (bus.done) o.seen_done = 1'b1;
      if (bus.done || bus.err) break;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic mt_write(input bit hw, input bit lw, input logic [31:0] d);
    @(negedge clk);
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.hilo_wdata = d;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.hi, bus.lo} !== 64'd0) begin
      n_bad++; $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo});
    end
    n_vec++;
    if ({bus.mlu_op1, bus.mlu_op2, bus.gpr_result} !== 96'd0) begin
      n_bad++; $display("FAIL reset_ops: got %h want 0", {bus.mlu_op1, bus.mlu_op2, bus.gpr_result});
    end
    n_vec++;
    if ({bus.stall, bus.done, bus.err, bus.mlu_start, bus.mlu_sign} !== 5'd0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000",
                        {bus.stall, bus.done, bus.err, bus.mlu_start, bus.mlu_sign});
    end
    rst = 1'b0;
  endtask

  task automatic test_mult();
    obs_t o;
    exp_t e;
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd0, 1'b0});
    drive_op(3'd0, 32'hFFFF_FFFE, 32'd3, o);
    n_vec++;
    if (!o.seen_done) begin n_bad++; $display("FAIL mult_done: got 0 want 1"); end
    else begin
      e = sb.pop_front();
      n_vec++;
      if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
        n_bad++; $display("FAIL mult_hilo: got %h want %h", {bus.hi, bus.lo}, {e.hi, e.lo});
      end
    end
    n_vec++;
    if (o.n_lat != 9) begin n_bad++; $display("FAIL mult_latency: got %0d want 9", o.n_lat); end
    n_vec++;
    if (o.n_start != 8) begin n_bad++; $display("FAIL mult_start_cycles: got %0d want 8", o.n_start); end
    n_vec++;
    if (!o.pre_stall || o.n_stall != 8) begin
      n_bad++; $display("FAIL mult_stall: got pre=%0b n=%0d want pre=1 n=8", o.pre_stall, o.n_stall);
    end
    n_vec++;
    if (o.sign !== 1'b1) begin n_bad++; $display("FAIL mult_sign: got %b want 1", o.sign); end
    @(negedge clk);
    n_vec++;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL mult_done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_multu();
    obs_t o;
    exp_t e;
    sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001, 32'd0, 1'b0});
    drive_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, o);
    n_vec++;
    if (o.sign !== 1'b0) begin n_bad++; $display("FAIL multu_sign: got %b want 0", o.sign); end
    n_vec++;
    if (!o.seen_done) begin n_bad++; $display("FAIL multu_done: got 0 want 1"); end
    else begin
      e = sb.pop_front();
      n_vec++;
      if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
        n_bad++; $display("FAIL multu_hilo: got %h want %h", {bus.hi, bus.lo}, {e.hi, e.lo});
      end
    end
  endtask

  task automatic test_mul();
    obs_t o;
    exp_t e;
    sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFDD, 1'b1});
    drive_op(3'd2, 32'd7, 32'hFFFF_FFFB, o);
    n_vec++;
    if (!o.seen_done) begin n_bad++; $display("FAIL mul_done: got 0 want 1"); end
    else begin
      e = sb.pop_front();
      n_vec++;
      if (bus.gpr_result !== e.gpr) begin
        n_bad++; $display("FAIL mul_gpr: got %h want %h", bus.gpr_result, e.gpr);
      end
      n_vec++;
      if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
        n_bad++; $display("FAIL mul_hilo_kept: got %h want %h", {bus.hi, bus.lo}, {e.hi, e.lo});
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   ndone = 0;
    int   done1 = 0;
    int   done2 = 0;
    int   rise2 = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 32'd2; bus.req_b = 32'd3;
    sb.push_back('{32'd0, 32'd6, 32'd0, 1'b0});
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.mlu_start && ndone == 1 && rise2 == 0) rise2 = c;
      if (bus.done) begin
        e = sb.pop_front();
        n_vec++;
        if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
          n_bad++; $display("FAIL b2b_hilo%0d: got %h want %h", ndone, {bus.hi, bus.lo}, {e.hi, e.lo});
        end
        ndone++;
        if (ndone == 1) begin
          done1 = c;
          bus.req_a = 32'd4; bus.req_b = 32'd5;
          sb.push_back('{32'd0, 32'd20, 32'd0, 1'b0});
        end else begin
          done2 = c;
          break;
        end
      end
    end
    bus.req_valid = 1'b0;
    n_vec++;
    if (done1 != 9 || rise2 != 11 || done2 != 19) begin
      n_bad++; $display("FAIL b2b_timing: got done1=%0d rise2=%0d done2=%0d want 9 11 19", done1, rise2, done2);
    end
  endtask

  task automatic test_mt_write();
    exp_t e;
    bit   got = 1'b0;
    mt_write(1'b1, 1'b0, 32'h1234_5678);
    mt_write(1'b0, 1'b1, 32'h9ABC_DEF0);
    n_vec++;
    if ({bus.hi, bus.lo} !== 64'h1234_5678_9ABC_DEF0) begin
      n_bad++; $display("FAIL mt_idle: got %h want 123456789abcdef0", {bus.hi, bus.lo});
    end
    // MT write in the accept cycle lands, capture later overwrites it
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 32'd2; bus.req_b = 32'd3;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.hilo_wdata = 32'h5555_AAAA;
    sb.push_back('{32'd0, 32'd6, 32'd0, 1'b0});
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_vec++;
        if ({bus.hi, bus.lo} !== {2{32'h5555_AAAA}}) begin
          n_bad++; $display("FAIL mt_with_accept: got %h want 5555aaaa5555aaaa", {bus.hi, bus.lo});
        end
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      end
      if (c == 2) begin bus.hi_we = 1'b1; bus.hilo_wdata = 32'hDEAD_BEEF; end
      if (c == 3) bus.hi_we = 1'b0;
      if (c == 4) begin
        n_vec++;
        if (bus.hi !== 32'h5555_AAAA) begin
          n_bad++; $display("FAIL mt_in_run_ignored: got %h want 5555aaaa", bus.hi);
        end
      end
      if (bus.done) begin
        got = 1'b1;
        e = sb.pop_front();
        n_vec++;
        if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
          n_bad++; $display("FAIL mt_capture_wins: got %h want %h", {bus.hi, bus.lo}, {e.hi, e.lo});
        end
        break;
      end
    end
    bus.req_valid = 1'b0;
    n_vec++;
    if (!got) begin n_bad++; $display("FAIL mt_done_timeout: got 0 want 1"); end
  endtask

  task automatic test_reserved();
    obs_t       o;
    exp_t       e;
    logic [2:0] ops[$];
    ops.push_back(3'd3);
`ifndef MLU_ACC_EN
    ops.push_back(3'd4);
    ops.push_back(3'd7);
`endif
    foreach (ops[k]) begin
      sb.push_back('{32'd0, 32'd6, 32'd0, 1'b0});
      drive_op(ops[k], 32'd9, 32'd9, o);
      n_vec++;
      if (!o.seen_done || o.n_lat != 1 || o.n_start != 0 || o.pre_stall) begin
        n_bad++;
        $display("FAIL nop_op%0d: got done=%0b lat=%0d start=%0d stall=%0b want 1 1 0 0",
                 ops[k], o.seen_done, o.n_lat, o.n_start, o.pre_stall);
      end
      if (o.seen_done) begin
        e = sb.pop_front();
        n_vec++;
        if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
          n_bad++; $display("FAIL nop_hilo_op%0d: got %h want %h", ops[k], {bus.hi, bus.lo}, {e.hi, e.lo});
        end
      end
      @(negedge clk);
      n_vec++;
      if (bus.done !== 1'b0) begin n_bad++; $display("FAIL nop_done_width_op%0d: got 1 want 0", ops[k]); end
    end
  endtask

  task automatic test_flush();
    bit bad_done = 1'b0;
    bit bad_err  = 1'b0;
    int late_start = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 32'd4; bus.req_b = 32'd5;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.done) bad_done = 1'b1;
      if (bus.err) bad_err = 1'b1;
      if (c >= 4 && bus.mlu_start) late_start++;
      if (c == 3) bus.flush = 1'b1;
      if (c == 4) begin
        n_vec++;
        if (bus.mlu_start !== 1'b0 || bus.stall !== 1'b0) begin
          n_bad++; $display("FAIL flush_gap: got start=%b stall=%b want 0 0", bus.mlu_start, bus.stall);
        end
        bus.flush = 1'b0; bus.req_valid = 1'b0;
      end
    end
    n_vec++;
    if (bad_done || bad_err || late_start != 0) begin
      n_bad++; $display("FAIL flush_quiet: got done=%0b err=%0b start=%0d want 0 0 0", bad_done, bad_err, late_start);
    end
    n_vec++;
    if ({bus.hi, bus.lo} !== {32'd0, 32'd6}) begin
      n_bad++; $display("FAIL flush_hilo: got %h want 0000000000000006", {bus.hi, bus.lo});
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    stub_hang = 1'b1;
    drive_op(3'd0, 32'd9, 32'd9, o);
    stub_hang = 1'b0;
    n_vec++;
    if (!o.seen_err || o.seen_done) begin
      n_bad++; $display("FAIL timeout_err: got err=%0b done=%0b want 1 0", o.seen_err, o.seen_done);
    end
    n_vec++;
    if (o.n_start != TIMEOUT + 1 || o.n_lat != TIMEOUT + 2) begin
      n_bad++; $display("FAIL timeout_cycles: got start=%0d lat=%0d want %0d %0d",
                        o.n_start, o.n_lat, TIMEOUT + 1, TIMEOUT + 2);
    end
    n_vec++;
    if ({bus.hi, bus.lo} !== {32'd0, 32'd6}) begin
      n_bad++; $display("FAIL timeout_hilo: got %h want 0000000000000006", {bus.hi, bus.lo});
    end
    @(negedge clk);
    n_vec++;
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL timeout_err_width: got 1 want 0"); end
  endtask

`ifdef MLU_ACC_EN
  task automatic test_acc();
    obs_t o;
    exp_t e;
    mt_write(1'b1, 1'b0, 32'd0);
    mt_write(1'b0, 1'b1, 32'hFFFF_FFFF);
    sb.push_back('{32'd1, 32'd0, 32'd0, 1'b0});
    drive_op(3'd5, 32'd1, 32'd1, o);
    n_vec++;
    if (!o.seen_done || o.n_lat != 9) begin
      n_bad++; $display("FAIL maddu_done: got done=%0b lat=%0d want 1 9", o.seen_done, o.n_lat);
    end else begin
      e = sb.pop_front();
      n_vec++;
      if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
        n_bad++; $display("FAIL maddu_hilo: got %h want %h", {bus.hi, bus.lo}, {e.hi, e.lo});
      end
    end
    mt_write(1'b1, 1'b1, 32'd0);
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0});
    drive_op(3'd6, 32'd1, 32'd1, o);
    n_vec++;
    if (!o.seen_done) begin n_bad++; $display("FAIL msub_done: got 0 want 1"); end
    else begin
      e = sb.pop_front();
      n_vec++;
      if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
        n_bad++; $display("FAIL msub_hilo: got %h want %h", {bus.hi, bus.lo}, {e.hi, e.lo});
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 32'd3; bus.req_b = 32'd3;
    @(posedge clk);
    repeat (4) @(negedge clk);
    n_vec++;
    if (bus.mlu_start !== 1'b1) begin n_bad++; $display("FAIL arst_pre_run: got 0 want 1"); end
    #2;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.stall, bus.done, bus.err, bus.mlu_start, bus.mlu_sign} !== 5'd0) begin
      n_bad++; $display("FAIL arst_ctrl: got %b want 00000",
                        {bus.stall, bus.done, bus.err, bus.mlu_start, bus.mlu_sign});
    end
    n_vec++;
    if ({bus.hi, bus.lo, bus.mlu_op1, bus.mlu_op2, bus.gpr_result} !== 160'd0) begin
      n_bad++; $display("FAIL arst_data: got %h want 0",
                        {bus.hi, bus.lo, bus.mlu_op1, bus.mlu_op2, bus.gpr_result});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.mlu_start !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++; $display("FAIL arst_idle: got start=%b done=%b want 0 0", bus.mlu_start, bus.done);
    end
  endtask

  initial begin
    rst            = 1'b1;
    stub_hang      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'd0;
    bus.req_a      = 32'd0;
    bus.req_b      = 32'd0;
    bus.flush      = 1'b0;
    bus.hi_we      = 1'b0;
    bus.lo_we      = 1'b0;
    bus.hilo_wdata = 32'd0;

    test_reset();
    test_mult();
    test_multu();
    test_mul();
    test_back_to_back();
    test_mt_write();
    test_reserved();
    test_flush();
    test_timeout();
`ifdef MLU_ACC_EN
    test_acc();
`endif
    test_async_reset();

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
